// File: rtl/serial_rx_align.sv
// Serial-to-parallel lane receiver: hunts for COM, locks after LOCK_COMS aligned COMs, then strobes data bytes.
// Latency: a byte is presented right after the edge that samples its LSB; no backpressure (free-running one-cycle strobe).
module serial_rx_align #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter logic [7:0]  IDL       = 8'h7C,
    parameter int unsigned LOCK_COMS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active_out,
    output logic [3:0] com_cnt
);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COMS);

    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_active;
    logic [3:0] r_com_cnt;

    logic [7:0] w_sr_nxt;
    logic       w_boundary;
    logic [3:0] w_cnt_inc;

    assign w_sr_nxt   = {r_sr[6:0], serial_in};
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_cnt_inc  = r_com_cnt + 4'd1;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
            r_com_cnt <= 4'd0;
        end else begin
            r_sr      <= w_sr_nxt;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_valid   <= 1'b0;
            case (r_state)
                SEARCH: begin
                    // Any bit phase may start a candidate; the boundary restarts here.
                    if (w_sr_nxt == COM) begin
                        r_bit_cnt <= 3'd0;
                        r_com_cnt <= 4'd1;
                        if (LOCK_N == 4'd1) begin
                            r_state  <= LOCKED;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (w_boundary) begin
                        if (w_sr_nxt == COM) begin
                            r_com_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LOCK_N) begin
                                r_state  <= LOCKED;
                                r_active <= 1'b1;
                            end
                        end else begin
                            r_com_cnt <= 4'd0;
                            r_state   <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary && (w_sr_nxt != COM) && (w_sr_nxt != IDL)) begin
                        r_data  <= w_sr_nxt;
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign active_out = r_active;
    assign com_cnt    = r_com_cnt;

endmodule

// File: tb/tb_serial_rx_align.sv
// Bench for serial_rx_align: array-level reference model feeds per-instance expectation queues checked by a monitor.
module tb_serial_rx_align;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;
    localparam int MAXB = 512;

    logic       clk_32f = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] data_out4, data_out1;
    logic       valid_out4, valid_out1;
    logic       active_out4, active_out1;
    logic [3:0] com_cnt4, com_cnt1;

    always #5 clk_32f = ~clk_32f;

    serial_rx_align #(.COM(COM), .IDL(IDL), .LOCK_COMS(4)) u_dut4 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out4),
        .valid_out (valid_out4),
        .active_out(active_out4),
        .com_cnt   (com_cnt4)
    );

    serial_rx_align #(.COM(COM), .IDL(IDL), .LOCK_COMS(1)) u_dut1 (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out1),
        .valid_out (valid_out1),
        .active_out(active_out1),
        .com_cnt   (com_cnt1)
    );

    typedef struct {
        int         e;
        logic [7:0] b;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    bit   in_reset = 1'b1;
    int   edge_no = 0;
    bit   bits[$];
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] exp_dat [2][MAXB];
    logic       exp_act [2][MAXB];
    logic [3:0] exp_cnt [2][MAXB];

    task automatic chk(int d, string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut_lock%0d edge=%0d got=%0h want=%0h", name, (d == 0) ? 4 : 1, edge_no, act, exp);
        end
    endtask

    // Byte formed by the 8 bits ending at stream index j; bits before the stream start read as 0 (cleared by reset).
    function automatic logic [7:0] win(int j);
        logic [7:0] w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            int idx = j - 7 + k;
            w = {w[6:0], (idx >= 0) ? bits[idx] : 1'b0};
        end
        return w;
    endfunction

    task automatic fill_cnt(int d, int e, logic [3:0] v);
        for (int k = e; k < bits.size(); k++) exp_cnt[d][k] = v;
    endtask

    task automatic push_exp(int d, int e, logic [7:0] v);
        exp_t x;
        x.e = e;
        x.b = v;
        for (int k = e; k < bits.size(); k++) exp_dat[d][k] = v;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // Scan the whole segment: find a COM at any offset, demand further COMs every 8 bits, then read data every 8 bits.
    task automatic run_model(int d, int lock_n);
        int n = bits.size();
        int j = 0;
        int b = 0;
        int cnt = 0;
        int lock_e = -1;
        logic [7:0] w;
        for (int k = 0; k < n; k++) begin
            exp_dat[d][k] = 8'h00;
            exp_act[d][k] = 1'b0;
            exp_cnt[d][k] = 4'd0;
        end
        while (j < n && lock_e < 0) begin
            if (win(j) != COM) begin
                j++;
                continue;
            end
            cnt = 1;
            fill_cnt(d, j, 4'd1);
            b = j;
            while (cnt < lock_n) begin
                b += 8;
                if (b >= n) break;
                if (win(b) == COM) begin
                    cnt++;
                    fill_cnt(d, b, 4'(cnt));
                end else begin
                    fill_cnt(d, b, 4'd0);
                    break;
                end
            end
            if (cnt == lock_n) lock_e = b;
            else               j = b + 1;
        end
        if (lock_e >= 0) begin
            for (int k = lock_e; k < n; k++) exp_act[d][k] = 1'b1;
            for (int e = lock_e + 8; e < n; e += 8) begin
                w = win(e);
                if (w != COM && w != IDL) push_exp(d, e, w);
            end
        end
    endtask

    task automatic mon(int d, logic v, logic a, logic [3:0] c, logic [7:0] dat);
        exp_t h;
        bit   ev = 1'b0;
        if (in_reset) begin
            chk(d, "rst_valid", 32'(v), 32'd0);
            chk(d, "rst_active", 32'(a), 32'd0);
            chk(d, "rst_com_cnt", 32'(c), 32'd0);
            chk(d, "rst_data", 32'(dat), 32'd0);
        end else begin
            if (d == 0) begin
                if (q0.size() > 0 && q0[0].e == edge_no) begin ev = 1'b1; h = q0.pop_front(); end
            end else begin
                if (q1.size() > 0 && q1[0].e == edge_no) begin ev = 1'b1; h = q1.pop_front(); end
            end
            chk(d, "valid", 32'(v), 32'(ev));
            if (ev) chk(d, "byte", 32'(dat), 32'(h.b));
            chk(d, "active", 32'(a), 32'(exp_act[d][edge_no]));
            chk(d, "com_cnt", 32'(c), 32'(exp_cnt[d][edge_no]));
            chk(d, "data_hold", 32'(dat), 32'(exp_dat[d][edge_no]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_32f);
            #1;
            mon(0, valid_out4, active_out4, com_cnt4, data_out4);
            mon(1, valid_out1, active_out1, com_cnt1, data_out1);
        end
    end

    task automatic push_byte(logic [7:0] v);
        for (int i = 7; i >= 0; i--) bits.push_back(v[i]);
    endtask

    task automatic push_rand_bits(int n);
        for (int i = 0; i < n; i++) bits.push_back(1'($urandom));
    endtask

    // Reset edges first (closing out the previous segment), then the queued bit stream.
    task automatic run_seg(int nrst);
        @(negedge clk_32f);
        reset = 1'b1;
        in_reset = 1'b1;
        serial_in = 1'($urandom);
        chk(0, "leftover", 32'(q0.size()), 32'd0);
        chk(1, "leftover", 32'(q1.size()), 32'd0);
        q0.delete();
        q1.delete();
        run_model(0, 4);
        run_model(1, 1);
        repeat (nrst - 1) begin
            @(negedge clk_32f);
            serial_in = 1'($urandom);
        end
        for (int i = 0; i < bits.size(); i++) begin
            @(negedge clk_32f);
            reset = 1'b0;
            in_reset = 1'b0;
            serial_in = bits[i];
            edge_no = i;
        end
    endtask

    initial begin
        logic [7:0] pick;
        int ncom;
        // Basic lock and data, including IDL and in-band COM after lock.
        bits.delete();
        push_rand_bits(3);
        repeat (4) push_byte(COM);
        push_byte(8'hA5); push_byte(8'h7C); push_byte(8'h3C); push_byte(8'hBC); push_byte(8'h01);
        run_seg(3);

        // Broken alignment, then relock on a phase shifted by one bit.
        bits.delete();
        push_byte(COM); push_byte(COM); push_byte(8'h55);
        push_rand_bits(1);
        repeat (4) push_byte(COM);
        push_byte(8'h5A); push_byte(8'h3F);
        run_seg(1);

        // Single-COM lock case.
        bits.delete();
        push_byte(COM); push_byte(8'hE7); push_byte(8'h00);
        run_seg(1);

        // Lock, then cut off mid-byte by reset, then relock.
        bits.delete();
        repeat (4) push_byte(COM);
        bits.push_back(1'b1); bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b0);
        run_seg(1);
        bits.delete();
        repeat (4) push_byte(COM);
        push_byte(8'h81);
        run_seg(1);

        // Randomized streams with random phase, random COM run lengths and mixed payload.
        for (int r = 0; r < 6; r++) begin
            bits.delete();
            push_rand_bits($urandom_range(0, 7));
            ncom = (r % 2 == 1) ? 4 : $urandom_range(1, 4);
            repeat (ncom) push_byte(COM);
            repeat (12) begin
                case ($urandom_range(0, 5))
                    0:       pick = COM;
                    1:       pick = IDL;
                    default: pick = 8'($urandom);
                endcase
                push_byte(pick);
            end
            run_seg($urandom_range(1, 3));
        end

        bits.delete();
        run_seg(1);
        @(negedge clk_32f);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_rx_align.md
# serial_rx_align

Receive-side serial-to-parallel deserializer with symbol alignment for one PHY lane. It samples one serial bit per `clk_32f` cycle, MSB first, and finds byte boundaries by hunting for the COM symbol 0xBC. It declares lock after a run of aligned COM symbols, then delivers data bytes with a one-cycle valid strobe. It sits between a lane's serial wire and the receive byte-unstriping logic, and mirrors the transmit parallel-to-serial path.

## Interface
Parameters:
- `COM`, default 8'hBC: alignment / inactive-lane symbol.
- `IDL`, default 8'h7C: active-but-no-data symbol.
- `LOCK_COMS`, default 4: aligned COMs required for lock, including the first detected one. Legal range 1..15.

Ports:
- `clk_32f`  input  1  bit clock; all logic is on its rising edge.
- `reset`  input  1  synchronous, active-high.
- `serial_in`  input  1  serial bit, MSB of each byte first.
- `data_out`  output  8  last received data byte.
- `valid_out`  output  1  one-cycle strobe; `data_out` holds a new data byte.
- `active_out`  output  1  high while in LOCKED.
- `com_cnt`  output  4  aligned COMs counted so far (debug).

## Operation
- Shift register: `sr <= {sr[6:0], serial_in}` every cycle. `sr_nxt` is the combinational `{sr[6:0], serial_in}`.
- `bit_cnt` is a 3-bit counter, 0..7. A byte boundary occurs on an edge where `bit_cnt==7`; `bit_cnt` then wraps to 0.
- States: SEARCH, ALIGN, LOCKED.
- SEARCH:
  - `sr_nxt` is checked against COM on every edge, with no boundary requirement.
  - On a match: `bit_cnt<=0`, `com_cnt<=1`, go to ALIGN. If `LOCK_COMS==1`, go directly to LOCKED.
  - Otherwise `bit_cnt` free-runs; its value is don't-care.
- ALIGN:
  - Only boundary edges are evaluated.
  - If `sr_nxt==COM`: `com_cnt<=com_cnt+1`. When the new count equals `LOCK_COMS`, go to LOCKED.
  - If `sr_nxt!=COM`: `com_cnt<=0`, go to SEARCH. The same edge does not re-check for COM; detection resumes on the next edge.
- LOCKED:
  - On each boundary edge: if `sr_nxt` is neither COM nor IDL, `data_out<=sr_nxt` and `valid_out<=1`. Otherwise `valid_out<=0` and `data_out` holds its value.
  - Stays in LOCKED until reset. There is no loss-of-lock detection.
  - `com_cnt` saturates at `LOCK_COMS` and holds.
- `valid_out` is 0 on every non-boundary edge.
- `active_out` is registered: `active_out<=1` on the edge that enters LOCKED.

## Timing
- Reset values: `sr=0`, `bit_cnt=0`, state SEARCH, `data_out=8'h00`, `valid_out=0`, `active_out=0`, `com_cnt=0`.
- Reset dominates all other activity. Asserting it mid-byte or while LOCKED returns to SEARCH on that edge and discards the partial byte.
- Latency:
  - A byte whose last bit (LSB) is sampled at edge k appears on `data_out`/`valid_out` right after edge k.
  - `valid_out` is high for exactly one cycle, and at most once every 8 cycles.
- Lock timing: with a first COM completing at edge k and continuous aligned COMs, `active_out` rises right after edge k+8·(`LOCK_COMS`−1). For the default 4, that is edge k+24.
- First data byte:
  - The earliest possible data byte is the 8 bits following the lock-completing COM.
  - Its `valid_out` is seen after edge k+8·`LOCK_COMS`.
- A false COM pattern straddling a boundary in SEARCH (for example `…0xB` followed by `C…`) is accepted. ALIGN then rejects it at the next boundary unless real COMs follow.
- `serial_in` X or Z during reset is ignored.

## Test plan
- Reset check: drive `reset=1` for 3 cycles with random `serial_in` → all outputs read back at their reset values; `valid_out` never rises.
- Basic lock and data:
  - Stimulus: 3 junk bits, then BC×4, then bytes A5, 7C, 3C, BC, 01.
  - `active_out` rises after the 4th BC.
  - `valid_out` pulses exactly 3 times, with `data_out`=A5, 3C, 01 in order and 8 cycles apart per byte slot.
  - `data_out` stays at A5 while 7C is received, and at 3C while BC is received.
- Broken alignment: BC, BC, then 55 → returns to SEARCH with `com_cnt=0`. Then BC×4 with a 1-bit phase shift → lock on the new phase, and subsequent 5A is received as 5A.
- `LOCK_COMS=1` instance: one BC then E7 → `active_out` rises after that BC; `valid_out` pulses with E7 eight edges later.
- Reset mid-operation:
  - After lock and 4 data bits of C3, assert `reset` for 1 cycle → `active_out=0`, `data_out=00`, state SEARCH.
  - Relock with BC×4 → the next byte 81 is delivered correctly.
